// File: rtl/uart_rx_core_if.sv
// Bus-side handshake of the UART receive engine: held byte, valid/ack and sticky error flags.
// Signal suffixes follow the direction seen from the core.
interface uart_rx_core_if;
  logic       rx_ack_i;
  logic       clr_err_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  modport slave (
    input  rx_ack_i,
    input  clr_err_i,
    output rx_data_o,
    output rx_valid_o,
    output frame_err_o,
    output overrun_o,
    output busy_o
  );

  modport master (
    output rx_ack_i,
    output clr_err_i,
    input  rx_data_o,
    input  rx_valid_o,
    input  frame_err_o,
    input  overrun_o,
    input  busy_o
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchroniser, mid-bit sampling FSM, one-entry holding register with
// valid/ack handshake and sticky framing/overrun flags.
module uart_rx_core #(
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               rx,
  uart_rx_core_if.slave      bus_io
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned Half = CLK_DIV >> 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   commit_q, commit_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   fe_set, ovr_set;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Bit-timing FSM; every state change reloads the counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    commit_d  = 1'b0;
    fe_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s) begin
            commit_d = 1'b1;
            state_d  = StIdle;
          end else begin
            fe_set  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: an ack coinciding with a commit frees the slot for the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (commit_q) begin
      if (!valid_q || bus_io.rx_ack_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (bus_io.rx_ack_i) begin
      valid_d = 1'b0;
    end
    frame_err_d = (frame_err_q & ~bus_io.clr_err_i) | fe_set;
    overrun_d   = (overrun_q & ~bus_io.clr_err_i) | ovr_set;
  end

  assign bus_io.rx_data_o   = data_q;
  assign bus_io.rx_valid_o  = valid_q;
  assign bus_io.frame_err_o = frame_err_q;
  assign bus_io.overrun_o   = overrun_q;
  assign bus_io.busy_o      = (state_q != StIdle);

endmodule
